// File: rtl/microwave_countdown_timer.sv
// ============================================================================
// microwave_countdown_timer : keypad-loaded MM:SS BCD countdown, stops at 00:00
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module microwave_countdown_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done
);

  localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic          b_so, b_st, b_mo;
  logic          dec_zero, time_nonzero, advance;

  // One-second decrement with borrow ripple; seconds tens wraps to 5.
  always_comb begin
    dec_so = so_q - 4'd1;
    b_so   = 1'b0;
    if (so_q == 4'd0) begin
      dec_so = 4'd9;
      b_so   = 1'b1;
    end
    dec_st = st_q;
    b_st   = 1'b0;
    if (b_so) begin
      if (st_q == 4'd0) begin
        dec_st = 4'd5;
        b_st   = 1'b1;
      end else begin
        dec_st = st_q - 4'd1;
      end
    end
    dec_mo = mo_q;
    b_mo   = 1'b0;
    if (b_st) begin
      if (mo_q == 4'd0) begin
        dec_mo = 4'd9;
        b_mo   = 1'b1;
      end else begin
        dec_mo = mo_q - 4'd1;
      end
    end
    dec_mt   = b_mo ? (mt_q - 4'd1) : mt_q;
    dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);
  end

  assign time_nonzero = ({mt_q, mo_q, st_q, so_q} != 16'h0000);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (cancel) begin
      state_d = S_IDLE;
      {mt_d, mo_d, st_d, so_d} = 16'h0000;
      presc_d = '0;
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (time_nonzero) begin
              state_d = S_RUN;
              presc_d = '0;
            end
          end else if (digit_valid && (digit_in <= 4'd9)) begin
            {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, digit_in};
          end
        end
        S_RUN:   advance = 1'b1;
        S_PAUSE: begin
          // The resume edge counts as a RUN cycle so paused time is excluded exactly.
          if (start) begin
            state_d = S_RUN;
            advance = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
          if (dec_zero) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign running  = (state_q == S_RUN);
  assign paused   = (state_q == S_PAUSE);
  assign done     = done_q;

endmodule

`default_nettype wire

// File: doc/microwave_countdown_timer.md
# microwave_countdown_timer

Cooking-time countdown for the timer and input control path. Keypad digits shift into an MM:SS BCD register. Start/stop/cancel commands run, pause or abort the countdown. The block decrements once per second from an internal prescaler and stops at 00:00 without wrapping, issuing a one-cycle `done` pulse that ends the cooking cycle. It is the down-counting, load-from-keypad counterpart to the non-recycling 0-to-7 up-counter.

## Interface

- `TICKS_PER_SEC`, default 100: clk cycles per countdown second (clk period 10 ms gives 1 s).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  reset, asynchronous and active-high; one clock domain.
- `digit_in`  in  4  BCD keypad digit; values 10–15 are ignored.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit_in`.
- `start`  in  1  one-cycle command: begin or resume the countdown.
- `stop`  in  1  one-cycle command: pause the countdown.
- `cancel`  in  1  one-cycle command: abort and clear the time.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  current time in BCD.
- `running`  out  1  high while in RUN.
- `paused`  out  1  high while in PAUSE.
- `done`  out  1  one-cycle pulse when the countdown reaches 00:00.

## Operation

- **States:** IDLE, RUN, PAUSE. All outputs are registered.
- **On `clear`:** the block enters IDLE immediately (not clock-synchronised). Digits, prescaler, `running`, `paused` and `done` all go to 0. This applies mid-RUN as well; no `done` is produced.
- **Command priority, per cycle:** `cancel` > `stop` > `start` > `digit_valid`. Lower-priority inputs in the same cycle are discarded.
- **IDLE, valid digit entry:** the time shifts left one digit.
  - `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`digit_in`.
  - The old `min_tens` is lost.
  - `sec_tens` may hold 6–9 (e.g. 00:90 means 90 s).
- **Digit entry outside IDLE:** ignored.
- **IDLE + `start`:**
  - Non-zero time: go to RUN and zero the prescaler.
  - Time 00:00: no effect.
- **RUN, prescaler:** counts 0..`TICKS_PER_SEC`-1 and wraps. The wrap cycle is a decrement tick.
- **Decrement rule:**
  - `sec_ones`: 0→9 with borrow, else −1.
  - On borrow, `sec_tens`: 0→5 with borrow, else −1.
  - On borrow, `min_ones`: 0→9 with borrow, else −1.
  - On borrow, `min_tens` −1.
- **Reaching zero:** on the tick that produces 00:00, the next state is IDLE and `done`=1 for exactly that one cycle. The time is never decremented below 00:00 (non-recycling).
- **RUN + `stop`:** go to PAUSE. The prescaler value is held, and no decrement happens in that cycle even if it is a tick cycle.
- **PAUSE + `start`:** return to RUN and resume the prescaler from its held value.
- **PAUSE + `stop`:** no effect.
- **`cancel` in any state:** go to IDLE, zero digits and prescaler, no `done`.
- **`start` in RUN:** no effect. It does not restart the prescaler.

## Timing

- Command latency: the state and `running`/`paused` change at the clock edge that samples the command.
- From the `start` edge, the first decrement is visible `TICKS_PER_SEC` cycles later. Subsequent decrements follow every `TICKS_PER_SEC` cycles of RUN.
- Total RUN time from `start` to `done` for value T seconds is T×`TICKS_PER_SEC` cycles, excluding PAUSE cycles.
- `done` is asserted in the same cycle the digits first read 0000, and `running` is 0 in that cycle.
- Digit entry is visible on the outputs one edge after the `digit_valid` sample.
- Reset is asynchronous: outputs read zero while `clear`=1, regardless of `clk`.

## Test plan

Use `TICKS_PER_SEC`=4 for all scenarios.

- **Reset and entry:**
  - Stimulus: assert `clear` mid-cycle.
  - Required response: all outputs become 0 immediately.
  - Stimulus: after release, enter digits 1, 2, 3, 4, 5.
  - Required response: time reads 23:45.
  - Stimulus: enter digit 12.
  - Required response: ignored, time stays 23:45.
- **Borrow chain:**
  - Stimulus: load 10:00, then `start`.
  - Required response: after 4 cycles the time reads 09:59.
  - Stimulus: continue running.
  - Required response: after 4 more cycles it reads 09:58.
- **Non-recycling end:**
  - Stimulus: load 00:03, then `start`.
  - Required response: `done` pulses exactly once, 12 cycles after `start`. Time holds 00:00, `running`=0, and there is no wrap to 99:59 over the next 20 cycles.
- **Pause/resume:**
  - Stimulus: load 00:02, `start`; `stop` 2 cycles later; wait 10 cycles; `start`.
  - Required response: `paused`=1 for 10 cycles with time frozen at 00:02. `done` arrives 6 cycles after the resume.
- **Priority and cancel:**
  - Stimulus: `stop` and `start` in the same cycle during RUN.
  - Required response: PAUSE is entered (`stop` wins).
  - Stimulus: `cancel` together with `start`.
  - Required response: IDLE with time 00:00 and no `done`.
  - Stimulus: `start` at 00:00.
  - Required response: stays in IDLE.
- **Entry over 59 seconds:**
  - Stimulus: load 00:90, `start`.
  - Required response: `done` after 360 cycles. The time passes 00:59 after 124 cycles.
